// File: rtl/alu_rr_sched_if.sv
// Request/response bundle between the requester blocks and alu_rr_sched.
// Packing: requester i uses [i*DATA_W +: DATA_W] for operands and [i*3 +: 3] for the opcode.
interface alu_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*3-1:0]      req_sel;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_zero;
  logic [ID_W-1:0]           rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_id
  );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one registered ALU between NUM_REQ requesters.
// Optional macro ALU_SCHED_PERF_EN adds saturating op_count/stall_count outputs.
module alu_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  alu_rr_sched_if.slave     bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
`ifdef ALU_SCHED_PERF_EN
  output logic [15:0]       op_count,
  output logic [15:0]       stall_count,
`endif
  output logic              busy
);
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   arb_id;
  logic [ID_W-1:0]   cand_id;
  logic              arb_found;
  logic [DATA_W-1:0] arb_a;
  logic [DATA_W-1:0] arb_b;
  logic [2:0]        arb_sel;

  // Search upward from rr_ptr+1 so the last winner has lowest priority.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    cand_id   = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      cand_id = ID_W'((32'(rr_ptr) + i) % NR);
      if (!arb_found && bus.req_valid[cand_id]) begin
        arb_found = 1'b1;
        arb_id    = cand_id;
      end
    end
  end

  always_comb begin
    arb_a   = '0;
    arb_b   = '0;
    arb_sel = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (ID_W'(i) == arb_id) begin
        arb_a   = bus.req_a[i*DATA_W +: DATA_W];
        arb_b   = bus.req_b[i*DATA_W +: DATA_W];
        arb_sel = bus.req_sel[i*3 +: 3];
      end
    end
  end

  // Gated by rst so nothing is accepted while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && state == IDLE && arb_found)
      bus.req_ready[arb_id] = 1'b1;
  end

  // alu_a/b/sel double as the operand latch: loaded at grant, held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      gnt_id        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sel       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_id    <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            alu_a   <= arb_a;
            alu_b   <= arb_b;
            alu_sel <= arb_sel;
            gnt_id  <= arb_id;
            rr_ptr  <= arb_id;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          bus.rsp_data  <= alu_out;
          bus.rsp_zero  <= alu_zero;
          bus.rsp_id    <= gnt_id;
          bus.rsp_valid <= NUM_REQ'(1) << gnt_id;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[gnt_id]) begin
            bus.rsp_valid <= '0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count    <= '0;
      stall_count <= '0;
    end else if (state == RESP) begin
      if (bus.rsp_ready[gnt_id]) begin
        if (op_count != '1) op_count <= op_count + 16'd1;
      end else begin
        if (stall_count != '1) stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with a behavioural registered ALU and a response scoreboard.
// Define ALU_SCHED_PERF_EN to also exercise the performance counters.
module tb_alu_rr_sched;
  localparam int NR = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       zero;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_sel;
  logic [DW-1:0] alu_out;
  logic          alu_zero;
  logic          busy;
`ifdef ALU_SCHED_PERF_EN
  logic [15:0]   op_count;
  logic [15:0]   stall_count;
`endif

  alu_rr_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  alu_rr_sched #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
`ifdef ALU_SCHED_PERF_EN
    .op_count    (op_count),
    .stall_count (stall_count),
`endif
    .busy        (busy)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] s);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ~a;
      3'b110:  return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  // Registered ALU, no reset, like the real instance.
  always @(posedge clk) begin
    alu_out  <= alu_f(alu_a, alu_b, alu_sel);
    alu_zero <= (alu_f(alu_a, alu_b, alu_sel) == 8'h00);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks    = 0;
  int            failures  = 0;
  int            cyc       = 0;
  int            grant_cyc = 0;
  exp_t          sb[$];
  int            grants[$];
  logic [NR-1:0] s_ready;
  logic [NR-1:0] s_rv;
  logic [NR-1:0] prev_rv;
  logic [7:0]    s_data;
  logic          s_zero;
  logic          s_busy;
  logic [1:0]    s_id;
  logic [7:0]    hs_data [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s);
    bus.req_a[id*8 +: 8]   = a;
    bus.req_b[id*8 +: 8]   = b;
    bus.req_sel[id*3 +: 3] = s;
    bus.req_valid[id]      = 1'b1;
  endtask

  // Samples the current cycle, logs grants/responses, then advances to posedge+1.
  task automatic tick();
    exp_t e;
    #1;
    s_ready = bus.req_ready;
    s_rv    = bus.rsp_valid;
    s_data  = bus.rsp_data;
    s_zero  = bus.rsp_zero;
    s_id    = bus.rsp_id;
    s_busy  = busy;
    chk("ready_onehot0", 32'($onehot0(s_ready)), 1);
    for (int i = 0; i < NR; i++) begin
      if (s_ready[i]) begin
        e.id   = 2'(i);
        e.data = alu_f(bus.req_a[i*8 +: 8], bus.req_b[i*8 +: 8], bus.req_sel[i*3 +: 3]);
        e.zero = (e.data == 8'h00);
        sb.push_back(e);
        grants.push_back(i);
        grant_cyc = cyc;
      end
    end
    if (s_rv != '0) begin
      if (prev_rv == '0) chk("latency", cyc - grant_cyc, 3);
      chk("sb_depth", sb.size(), 1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk("rsp_valid_onehot", 32'(s_rv), 32'(4'b0001 << e.id));
        chk("rsp_id", 32'(s_id), 32'(e.id));
        chk("rsp_data", 32'(s_data), 32'(e.data));
        chk("rsp_zero", 32'(s_zero), 32'(e.zero));
        chk("busy_resp", 32'(s_busy), 1);
        if ((s_rv & bus.rsp_ready) != '0) begin
          hs_data[e.id] = s_data;
          void'(sb.pop_front());
        end
      end
    end
    prev_rv = s_rv;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_zero", 32'(bus.rsp_zero), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_sel", 32'(alu_sel), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef ALU_SCHED_PERF_EN
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_stall_count", 32'(stall_count), 0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst           = 1'b0;
    sb.delete();
    prev_rv = '0;
  endtask

  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] s);
    int n = 0;
    set_req(id, a, b, s);
    do begin
      tick();
      n++;
    end while (!s_ready[id] && n < 20);
    chk("grant_seen", 32'(s_ready[id]), 1);
    bus.req_valid[id] = 1'b0;
    chk("issue_alu_a", 32'(alu_a), 32'(a));
    chk("issue_alu_b", 32'(alu_b), 32'(b));
    chk("issue_alu_sel", 32'(alu_sel), 32'(s));
  endtask

  // rsp_ready[id] is held low for 'stall' RESP cycles before the handshake.
  task automatic finish(input int id, input int stall, input logic [7:0] exp_d);
    int n = 0;
    bus.rsp_ready[id] = (stall == 0);
    do begin
      tick();
      n++;
    end while (!s_rv[id] && n < 20);
    chk("rsp_seen", 32'(s_rv[id]), 1);
    chk("op_data", 32'(s_data), 32'(exp_d));
    chk("op_zero", 32'(s_zero), 32'(exp_d == 8'h00));
    if (stall > 0) begin
      for (int k = 1; k < stall; k++) begin
        tick();
        chk("no_grant_in_resp", 32'(s_ready), 0);
      end
      bus.rsp_ready[id] = 1'b1;
      tick();
    end
    tick();
    chk("rsp_dropped", 32'(s_rv), 0);
  endtask

  initial begin
    int n;
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = '1;
    prev_rv       = '0;
    for (int i = 0; i < NR; i++) hs_data[i] = 8'h00;
    #2;
    do_reset();

    // Single request and zero result.
    issue(0, 8'h05, 8'h03, 3'b000);
    finish(0, 0, 8'h08);
    chk("idle_busy", 32'(s_busy), 0);
    issue(2, 8'h3C, 8'h3C, 3'b001);
    finish(2, 0, 8'h00);

    // Backpressure with req0 pending.
    issue(3, 8'h81, 8'h00, 3'b110);
    set_req(0, 8'h11, 8'h22, 3'b000);
    finish(3, 5, 8'h02);
    chk("pending_req0_granted", 32'(s_ready), 32'(4'b0001));
    bus.req_valid[0] = 1'b0;
    finish(0, 0, 8'h33);

    // Full contention from reset.
    do_reset();
    set_req(0, 8'h11, 8'h22, 3'b000);
    set_req(1, 8'hF0, 8'h0F, 3'b011);
    set_req(2, 8'h55, 8'h0F, 3'b010);
    set_req(3, 8'h81, 8'h00, 3'b111);
    grants.delete();
    n = 0;
    while (grants.size() < 5 && n < 60) begin
      tick();
      n++;
    end
    bus.req_valid = '0;
    chk("grant_count", grants.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("grant_order", (k < grants.size()) ? grants[k] : -1, k % 4);
    for (int k = 0; k < 6; k++) tick();
    chk("sb_drained", sb.size(), 0);
    chk("contention_req1", 32'(hs_data[1]), 32'h0000_00FF);
    chk("contention_req2", 32'(hs_data[2]), 32'h0000_0005);
    chk("contention_req3", 32'(hs_data[3]), 32'h0000_0040);

    // Reset during WAIT.
    issue(1, 8'hF0, 8'h0F, 3'b011);
    tick();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("no_rsp_after_reset", 32'(s_rv), 0);
    end
    set_req(1, 8'h10, 8'h01, 3'b000);
    set_req(0, 8'h05, 8'h03, 3'b000);
    tick();
    chk("first_after_reset", 32'(s_ready), 32'(4'b0001));
    bus.req_valid = '0;
    finish(0, 0, 8'h08);

`ifdef ALU_SCHED_PERF_EN
    do_reset();
    issue(0, 8'h01, 8'h01, 3'b000);
    finish(0, 0, 8'h02);
    issue(1, 8'h0F, 8'hF0, 3'b100);
    finish(1, 2, 8'hFF);
    issue(2, 8'hFF, 8'h01, 3'b000);
    finish(2, 0, 8'h00);
    chk("op_count", 32'(op_count), 3);
    chk("stall_count", 32'(stall_count), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
